// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the register-file writeback
//               arbiter and its load FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int REG_ZERO  = 0;
  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_fifo.sv
// ============================================================================
// Module      : wb_load_fifo
// Description : DEPTH-entry load-return FIFO with per-entry destination and
//               valid outputs for the writeback scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [ADDR_W-1:0]             wr_rd_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic [ADDR_W-1:0]             head_rd_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_rd_o,
  output logic [DEPTH-1:0]              entry_vld_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: validity is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem_q[wr_ptr_q]   <= wr_rd_i;
      data_mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] w_offset;
    assign w_offset       = PTR_W'(i) - rd_ptr_q;
    assign entry_rd_o[i]  = rd_mem_q[i];
    assign entry_vld_o[i] = ({1'b0, w_offset} < count_q);
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Drives the register-file write port from an ALU result stream
//               (priority) and a buffered load-return stream, with starvation
//               back-pressure and a pending-load scoreboard.
//               Optional: WB_BYPASS_EN writes a load straight through when the
//               FIFO is empty and the ALU does not claim the port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  input  logic [ADDR_W-1:0]      query_reg1,
  input  logic [ADDR_W-1:0]      query_reg2,
  output logic                   query_hit1,
  output logic                   query_hit2,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int                SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] RZ         = ADDR_W'(REG_ZERO);

  logic                         w_full, w_empty;
  logic [ADDR_W-1:0]            w_head_rd;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0][ADDR_W-1:0] w_entry_rd;
  logic [DEPTH-1:0]             w_entry_vld;
  logic                         w_push, w_pop, w_alu_win, w_bypass;
  logic [SC_W-1:0]              starve_cnt_q, starve_cnt_d;

  wb_load_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .wr_rd_i     (mem_rd),
    .wr_data_i   (mem_data),
    .head_rd_o   (w_head_rd),
    .head_data_o (w_head_data),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (fifo_count),
    .entry_rd_o  (w_entry_rd),
    .entry_vld_o (w_entry_vld)
  );

  // An ALU result to r0 completes its handshake but leaves the port free.
  always_comb begin
    alu_ready = reset_n && (starve_cnt_q != STARVE_MAX);
    mem_ready = reset_n && !w_full;
    w_alu_win = alu_valid && alu_ready && (alu_rd != RZ);
    w_pop     = reset_n && !w_alu_win && !w_empty;
    w_bypass  = 1'b0;
`ifdef WB_BYPASS_EN
    w_bypass  = reset_n && !w_alu_win && w_empty && mem_valid && mem_ready && (mem_rd != RZ);
`endif
    w_push    = mem_valid && mem_ready && (mem_rd != RZ) && !w_bypass;
  end

  always_comb begin
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    if (w_alu_win) begin
      reg_write  = 1'b1;
      write_reg  = alu_rd;
      write_data = alu_data;
    end else if (w_pop) begin
      reg_write  = 1'b1;
      write_reg  = w_head_rd;
      write_data = w_head_data;
    end else if (w_bypass) begin
      reg_write  = 1'b1;
      write_reg  = mem_rd;
      write_data = mem_data;
    end
  end

  // A saturated counter forces alu_ready low, so the head always pops next.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (w_pop || w_empty)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + SC_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end

  always_comb begin
    query_hit1 = 1'b0;
    query_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_vld[i] && (w_entry_rd[i] == query_reg1)) query_hit1 = 1'b1;
      if (w_entry_vld[i] && (w_entry_rd[i] == query_reg2)) query_hit2 = 1'b1;
    end
    if (query_reg1 == RZ) query_hit1 = 1'b0;
    if (query_reg2 == RZ) query_hit2 = 1'b0;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback-side initiator that drives the register file's single write port (reg_write, write_reg, write_data).
- Merges two result sources:
  - ALU results: valid/ready, priority source.
  - Memory load returns: valid/ready, buffered in a DEPTH-entry FIFO.
- Provides scoreboard query ports so decode can stall on registers with a buffered load still pending.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 registers; index 0 is hard-wired zero).
- DEPTH, 4, load FIFO entries; power of 2, minimum 2.
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before the ALU is back-pressured; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load return present.
- mem_ready  out  1  FIFO can accept; equals !full.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- reg_write  out  1  write strobe to the register file.
- write_reg  out  ADDR_W  write index.
- write_data  out  DATA_W  write data.
- query_reg1  in  ADDR_W  scoreboard lookup 1.
- query_reg2  in  ADDR_W  scoreboard lookup 2.
- query_hit1  out  1  a valid FIFO entry targets query_reg1.
- query_hit2  out  1  a valid FIFO entry targets query_reg2.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO pointers and count cleared; starve_cnt cleared.
  - All outputs 0, including alu_ready and mem_ready.
  - Write outputs are gated to 0 while reset_n is low.
- Write port is combinational:
  - The register file commits on the same rising edge on which reg_write is high.
  - When reg_write=0, write_reg and write_data are 0.
- Arbitration, evaluated each cycle:
  - alu_ready = !(starve_cnt == STARVE_LIMIT).
  - If alu_valid, alu_ready and alu_rd != 0: drive the ALU write; FIFO does not pop.
  - Otherwise, if the FIFO is non-empty: pop the head and drive its write.
  - Otherwise: reg_write = 0.
- r0 handling:
  - ALU result with rd=0: handshake completes, no write. The port counts as free, so the FIFO head may pop that same cycle.
  - Load with rd=0: accepted (mem_ready honoured) but not pushed.
- FIFO:
  - Push when mem_valid && mem_ready && mem_rd != 0.
  - mem_ready depends only on registered count; no pop-through when full.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full: count unchanged.
  - Order within each source is preserved. No ordering guarantee between sources; the pipeline prevents same-register ALU/load overlap using query_hit.
- Starvation counter:
  - Increments when the FIFO is non-empty and the head did not pop.
  - Clears on every pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT. While saturated, alu_ready=0, so the head pops that cycle and the counter clears.
- Latency: a load accepted at edge N is written no earlier than the cycle after edge N (FIFO path), unless WB_BYPASS_EN is defined.
- Scoreboard:
  - query_hitX = OR over valid entries of (entry.rd == query_regX).
  - Combinational on current FIFO state.
  - query_regX = 0 always gives 0.
- Reset mid-operation: buffered loads are discarded; no write is issued.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if the FIFO is empty, no ALU write wins this cycle, and mem_valid && mem_rd != 0, the load is written directly in the same cycle (zero-cycle latency) and not pushed. query_hit is unaffected by bypassed loads.
- Undefined: every load passes through the FIFO; minimum one cycle from acceptance to write.

Decomposition:
- Shared package wb_pkg:
  - typedef wb_entry_t {rd[ADDR_W], data[DATA_W]}.
  - Constants REG_ZERO = 0 and REG_COUNT = 32.
- One sub-module: wb_load_fifo (storage, pointers, count, full/empty, per-entry rd outputs for the scoreboard compare).
- Arbiter, starvation counter and scoreboard stay in the top.

Test Plan:
1. Load rd=5 data=0xDEADBEEF, ALU idle → reg_write=1, write_reg=5, write_data=0xDEADBEEF on the next cycle. fifo_count goes 1 → 0; query_reg1=5 gives hit=1 for exactly one cycle.
2. alu_valid held high, rd=7, every cycle; one load rd=9 queued with STARVE_LIMIT=4:
   - ALU writes for 4 cycles.
   - Cycle 5: alu_ready=0 and r9 is written.
   - Cycle 6: ALU resumes.
3. Push 4 loads with no pops (ALU saturating, STARVE_LIMIT large) → mem_ready=0, fifo_count=4. A fifth mem_valid is held off and not lost. After one pop, mem_ready=1.
4. alu_valid with alu_rd=0 and FIFO holding rd=3 → alu_ready=1, no ALU write, r3 written that same cycle.
5. Load with mem_rd=0 → accepted, fifo_count stays 0, no write. Assert reset_n low with 3 entries queued → all outputs 0 immediately, fifo_count=0, no later writes.
6. WB_BYPASS_EN defined, FIFO empty, ALU idle, load rd=12 → reg_write=1, write_reg=12 in the same cycle; fifo_count stays 0.
